// File: rtl/div_unit_pkg.sv
// Shared definitions for the 32-bit restoring divider: widths, iteration count,
// FSM encoding and sign helpers.
package div_unit_pkg;

  localparam int DATA_W   = 32;
  localparam int ITER_CNT = 32;
  localparam int CNT_W    = 6;

  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(ITER_CNT - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } div_state_e;

  function automatic logic [DATA_W-1:0] magnitude(input logic [DATA_W-1:0] value,
                                                   input logic            is_signed);
    if (is_signed && value[DATA_W-1]) begin
      magnitude = ~value + DATA_W'(1);
    end else begin
      magnitude = value;
    end
  endfunction

  function automatic logic [DATA_W-1:0] cond_negate(input logic [DATA_W-1:0] value,
                                                     input logic            negate);
    if (negate) begin
      cond_negate = ~value + DATA_W'(1);
    end else begin
      cond_negate = value;
    end
  endfunction

endpackage

// File: rtl/div_step.sv
// One radix-2 restoring division step: shift the next dividend bit into the
// partial remainder, trial-subtract the divisor and shift the quotient bit in.
module div_step
  import div_unit_pkg::*;
(
  input  logic [DATA_W-1:0] rem_in,
  input  logic [DATA_W-1:0] quo_in,
  input  logic [DATA_W-1:0] divisor,
  output logic [DATA_W-1:0] rem_out,
  output logic [DATA_W-1:0] quo_out
);

  logic [DATA_W:0] shifted_s;
  logic [DATA_W:0] diff_s;

  assign shifted_s = {rem_in, quo_in[DATA_W-1]};
  assign diff_s    = shifted_s - {1'b0, divisor};

  // Keep the difference when it did not borrow, otherwise restore the shifted value.
  always_comb begin
    rem_out = shifted_s[DATA_W-1:0];
    quo_out = {quo_in[DATA_W-2:0], 1'b0};
    if (!diff_s[DATA_W]) begin
      rem_out = diff_s[DATA_W-1:0];
      quo_out = {quo_in[DATA_W-2:0], 1'b1};
    end else begin
      rem_out = shifted_s[DATA_W-1:0];
      quo_out = {quo_in[DATA_W-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/div_unit.sv
// Multi-cycle 32-bit signed/unsigned divider: 32 restoring steps on magnitudes,
// sign fix-up on the final edge, with cancel and back-to-back start support.
module div_unit
  import div_unit_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              is_signed,
  input  logic [DATA_W-1:0] dividend,
  input  logic [DATA_W-1:0] divisor,
  input  logic              cancel,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] quotient,
  output logic [DATA_W-1:0] remainder
);

  div_state_e        state_r;
  logic [CNT_W-1:0]  cnt_r;
  logic [DATA_W-1:0] rem_r;
  logic [DATA_W-1:0] quo_r;
  logic [DATA_W-1:0] dvs_r;
  logic              neg_q_r;
  logic              neg_r_r;
  logic              busy_r;
  logic              done_r;
  logic [DATA_W-1:0] quotient_r;
  logic [DATA_W-1:0] remainder_r;

  logic [DATA_W-1:0] step_rem_s;
  logic [DATA_W-1:0] step_quo_s;
  logic              launch_s;

  assign launch_s = start & ~cancel;

  div_step u_step (
    .rem_in  (rem_r),
    .quo_in  (quo_r),
    .divisor (dvs_r),
    .rem_out (step_rem_s),
    .quo_out (step_quo_s)
  );

  // Control FSM, datapath registers and registered result outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= IDLE;
      cnt_r       <= '0;
      rem_r       <= '0;
      quo_r       <= '0;
      dvs_r       <= '0;
      neg_q_r     <= 1'b0;
      neg_r_r     <= 1'b0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      quotient_r  <= '0;
      remainder_r <= '0;
    end else begin
      case (state_r)
        IDLE, DONE: begin
          done_r <= 1'b0;
          if (launch_s) begin
            state_r <= CALC;
            busy_r  <= 1'b1;
            cnt_r   <= '0;
            rem_r   <= '0;
            quo_r   <= magnitude(dividend, is_signed);
            dvs_r   <= magnitude(divisor, is_signed);
            // A zero divisor must produce all-ones, so it never flips the quotient sign.
            neg_q_r <= is_signed & (dividend[DATA_W-1] ^ divisor[DATA_W-1]) &
                       (divisor != '0);
            neg_r_r <= is_signed & dividend[DATA_W-1];
          end else begin
            state_r <= IDLE;
            busy_r  <= 1'b0;
          end
        end
        CALC: begin
          if (cancel) begin
            state_r <= IDLE;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
          end else begin
            rem_r <= step_rem_s;
            quo_r <= step_quo_s;
            cnt_r <= cnt_r + CNT_W'(1);
            if (cnt_r == LAST_STEP) begin
              state_r     <= DONE;
              busy_r      <= 1'b0;
              done_r      <= 1'b1;
              quotient_r  <= cond_negate(step_quo_s, neg_q_r);
              remainder_r <= cond_negate(step_rem_s, neg_r_r);
            end else begin
              state_r <= CALC;
              busy_r  <= 1'b1;
              done_r  <= 1'b0;
            end
          end
        end
        default: begin
          state_r <= IDLE;
          busy_r  <= 1'b0;
          done_r  <= 1'b0;
        end
      endcase
    end
  end

  assign busy      = busy_r;
  assign done      = done_r;
  assign quotient  = quotient_r;
  assign remainder = remainder_r;

endmodule

// File: doc/div_unit.md
DIV_UNIT -- requirements
Module: div_unit

Interface
REQ-001 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-002 SHALL have port: rst  input  1  reset, asynchronous, active-high.
REQ-003 SHALL have port: start  input  1  request a divide; sampled only in IDLE or DONE.
REQ-004 SHALL have port: is_signed  input  1  1 = signed (DIV), 0 = unsigned (DIVU); captured with start.
REQ-005 SHALL have port: dividend  input  32  rs operand; captured with start.
REQ-006 SHALL have port: divisor  input  32  rt operand; captured with start.
REQ-007 SHALL have port: cancel  input  1  pipeline flush; aborts an in-flight divide.
REQ-008 SHALL have port: busy  output  1  divide in progress; drives the hazard unit's DIV_Busy stall input.
REQ-009 SHALL have port: done  output  1  one-cycle pulse; quotient/remainder valid.
REQ-010 SHALL have port: quotient  output  32  result for LO.
REQ-011 SHALL have port: remainder  output  32  result for HI.

Function
REQ-012 SHALL implement FSM states IDLE, CALC, DONE.
REQ-013 IDLE/DONE with start=1, cancel=0 at edge N: SHALL capture operands, enter CALC at N+1, clear 6-bit iteration counter.
REQ-014 CALC: SHALL perform one radix-2 restoring step per cycle on 32-bit magnitudes; exactly 32 steps.
REQ-015 After the 32nd step SHALL enter DONE and register quotient/remainder in the same edge; start edge to done=1 is 33 cycles.
REQ-016 busy SHALL be 1 exactly while state==CALC; registered, no combinational path from start.
REQ-017 done SHALL be 1 only in the single DONE cycle.
REQ-018 DONE with start=0 SHALL return to IDLE; DONE with start=1 SHALL begin a new divide (back-to-back).
REQ-019 start while in CALC SHALL be ignored; operands and counter unaffected.
REQ-020 cancel=1 in CALC SHALL go to IDLE next cycle, busy=0, no done pulse, outputs keep previous values.
REQ-021 cancel=1 together with start in IDLE/DONE SHALL suppress the start (cancel wins).
REQ-022 quotient/remainder SHALL hold their last values until the next DONE.
REQ-023 Signed: SHALL divide absolute values; negate quotient when operand signs differ; remainder takes the dividend's sign.
REQ-024 Signed 0x80000000 / 0xFFFFFFFF SHALL yield quotient 0x80000000, remainder 0.
REQ-025 divisor==0 SHALL still take 33 cycles and yield quotient 0xFFFFFFFF, remainder = dividend, for both signed and unsigned.
REQ-026 All arithmetic SHALL be 32-bit with a 33-bit partial-remainder subtractor; no overflow flag.

Reset
REQ-027 rst=1 SHALL asynchronously force state=IDLE, counter=0, busy=0, done=0, quotient=0, remainder=0.
REQ-028 rst mid-CALC SHALL abort without a done pulse; first start after release SHALL behave as from power-up.

Structure
REQ-029 A shared package SHALL hold the FSM state encoding, data width 32, and iteration count 32.
REQ-030 One combinational sub-module, div_step (one restoring step: partial remainder, shifted quotient in; updated pair out), SHALL be natural; all else stays in div_unit.

Verification
REQ-031 Unsigned 100/7, start at cycle 0 -> busy cycles 1-32, done at cycle 33, quotient=14, remainder=2.
REQ-032 Signed 0xFFFFFFF9 (-7) / 2 -> quotient=0xFFFFFFFD, remainder=0xFFFFFFFF; unsigned same operands -> quotient=0x7FFFFFFC, remainder=1.
REQ-033 5/0 (both modes) -> quotient=0xFFFFFFFF, remainder=5, done at cycle 33; signed 0x80000000/0xFFFFFFFF -> quotient=0x80000000, remainder=0.
REQ-034 cancel at cycle 10 of CALC -> busy=0 at cycle 11, no done, outputs unchanged; start at cycle 5 of CALC -> ignored, original result delivered.
REQ-035 rst asserted mid-CALC (asynchronously, between edges) -> busy/done/outputs 0 immediately; new 9/3 afterwards -> quotient=3, remainder=0 after 33 cycles.
REQ-036 start held in DONE cycle with 20/6 -> busy next cycle, second done 33 cycles later, quotient=3, remainder=2.
